// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and address/size helpers
// for the command-to-AHB master.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  // cmd_size 3 has no wider bus equivalent and is treated as a word
  function automatic logic [2:0] map_size(input logic [1:0] size);
    return (size == 2'd3) ? HSIZE_WORD : {1'b0, size};
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                             input logic [1:0]  size);
    case (size)
      2'd0:    return addr;
      2'd1:    return {addr[31:1], 1'b0};
      default: return {addr[31:2], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/ahb_byte_lanes.sv
// Little-endian byte-lane steering: write-data replication and read-lane
// extraction with zero-extension, selected by transfer size and addr[1:0].
module ahb_byte_lanes
  import ahb_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wlanes,
  output logic [31:0] rext
);

  always_comb begin
    wlanes = wdata;
    rext   = rdata;
    case (size)
      HSIZE_BYTE: begin
        wlanes = {4{wdata[7:0]}};
        rext   = {24'b0, rdata[{addr_lo, 3'b000} +: 8]};
      end
      HSIZE_HALF: begin
        wlanes = {2{wdata[15:0]}};
        rext   = {16'b0, rdata[{addr_lo[1], 4'b0000} +: 16]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer master: one NONSEQ/SINGLE transfer per local
// command, address and data phases never overlapped.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  state_t      state, state_n;
  logic [31:0] wdata_q, wdata_n;
  logic [31:0] haddr_n, hwdata_n, rsp_rdata_n;
  logic [2:0]  hsize_n;
  logic [1:0]  htrans_n;
  logic        hwrite_n, rsp_valid_n, rsp_err_n;
  logic [31:0] wlanes, rext;

  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign cmd_ready = (state == ST_IDLE) && !HRESET;

  // HADDR/HSIZE stay valid through the data phase, so they drive read steering
  ahb_byte_lanes u_lanes (
    .size    (HSIZE),
    .addr_lo (HADDR[1:0]),
    .wdata   (wdata_q),
    .rdata   (HRDATA),
    .wlanes  (wlanes),
    .rext    (rext)
  );

  always_comb begin
    state_n     = state;
    wdata_n     = wdata_q;
    haddr_n     = HADDR;
    hsize_n     = HSIZE;
    htrans_n    = HTRANS;
    hwrite_n    = HWRITE;
    hwdata_n    = HWDATA;
    rsp_valid_n = 1'b0;
    rsp_err_n   = rsp_err;
    rsp_rdata_n = rsp_rdata;
    case (state)
      ST_IDLE: begin
        htrans_n = HTRANS_IDLE;
        if (cmd_valid) begin
          haddr_n  = align_addr(cmd_addr, cmd_size);
          hsize_n  = map_size(cmd_size);
          hwrite_n = cmd_write;
          htrans_n = HTRANS_NONSEQ;
          wdata_n  = cmd_wdata;
          state_n  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          htrans_n = HTRANS_IDLE;
          if (HWRITE) hwdata_n = wlanes;
          state_n  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = HRESP;
          rsp_rdata_n = (!HWRITE && HRESP == HRESP_OKAY) ? rext : '0;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wdata_q   <= '0;
      HADDR     <= '0;
      HSIZE     <= HSIZE_WORD;
      HTRANS    <= HTRANS_IDLE;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      wdata_q   <= wdata_n;
      HADDR     <= haddr_n;
      HSIZE     <= hsize_n;
      HTRANS    <= htrans_n;
      HWRITE    <= hwrite_n;
      HWDATA    <= hwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
    end
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: per-cycle bus checks plus a response
// scoreboard filled at command issue and drained on rsp_valid.
module tb_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  always #5 HCLK = ~HCLK;

  ahb_cmd_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned fails  = 0;
  logic [31:0] hwdata_exp = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [1:0] s);
    case (s)
      2'd0:    return a;
      2'd1:    return a & ~32'h1;
      default: return a & ~32'h3;
    endcase
  endfunction

  function automatic logic [31:0] exp_size(input logic [1:0] s);
    return (s == 2'd3) ? 32'd2 : {30'b0, s};
  endfunction

  function automatic logic [31:0] exp_lanes(input logic [31:0] w, input logic [1:0] s);
    case (s)
      2'd0:    return (w & 32'hFF) * 32'h01010101;
      2'd1:    return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_extract(input logic [31:0] r, input logic [31:0] a,
                                              input logic [1:0] s);
    logic [1:0] lo;
    lo = a[1:0];
    case (s)
      2'd0:    return (r >> (8 * lo)) & 32'hFF;
      2'd1:    return (r >> (16 * lo[1])) & 32'hFFFF;
      default: return r;
    endcase
  endfunction

  always @(negedge HCLK) begin
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", {31'b0, rsp_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge where rsp_valid is high
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wdata, input int unsigned aw, input int unsigned dw,
                      input logic [31:0] rdata, input logic err, input string tag);
    rsp_t e;
    chk($sformatf("%s.ready", tag), {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
    HREADY = 1'b0; HRESP = 1'b0;
    @(negedge HCLK);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
    e.rdata = (wr || err) ? 32'd0 : exp_extract(rdata, addr, size);
    e.err   = err;
    exp_q.push_back(e);
    for (int unsigned i = 0; i <= aw; i++) begin
      chk($sformatf("%s.htrans_a", tag), {30'b0, HTRANS}, 32'h2);
      chk($sformatf("%s.haddr", tag), HADDR, exp_addr(addr, size));
      chk($sformatf("%s.hwrite", tag), {31'b0, HWRITE}, {31'b0, wr});
      chk($sformatf("%s.hsize", tag), {29'b0, HSIZE}, exp_size(size));
      chk($sformatf("%s.busy", tag), {31'b0, cmd_ready}, 32'd0);
      if (i < aw) begin HREADY = 1'b0; HRESP = 1'b1; end
      else        begin HREADY = 1'b1; HRESP = 1'b0; end
      HRDATA = $urandom;
      @(negedge HCLK);
    end
    if (wr) hwdata_exp = exp_lanes(wdata, size);
    for (int unsigned i = 0; i <= dw; i++) begin
      chk($sformatf("%s.htrans_d", tag), {30'b0, HTRANS}, 32'h0);
      chk($sformatf("%s.hwdata", tag), HWDATA, hwdata_exp);
      if (i < dw) begin
        HREADY = 1'b0; HRESP = err && (i == dw - 1); HRDATA = $urandom;
      end else begin
        HREADY = 1'b1; HRESP = err; HRDATA = rdata;
      end
      @(negedge HCLK);
    end
    HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom;
    chk($sformatf("%s.rsp_valid", tag), {31'b0, rsp_valid}, 32'd1);
  endtask

  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("rst.haddr", HADDR, 32'd0);
    chk("rst.htrans", {30'b0, HTRANS}, 32'd0);
    chk("rst.hwrite", {31'b0, HWRITE}, 32'd0);
    chk("rst.hsize", {29'b0, HSIZE}, 32'd2);
    chk("rst.hwdata", HWDATA, 32'd0);
    chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst.cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst.hburst", {29'b0, HBURST}, 32'd0);
    chk("rst.hmastlock", {31'b0, HMASTLOCK}, 32'd0);
    chk("rst.hprot", {28'b0, HPROT}, 32'h3);
    HRESET = 1'b0;
    @(negedge HCLK);

    xfer(1'b1, 32'hBF000004, 2'd2, 32'h0, 0, 0, 32'h0, 1'b0, "wr_word");
    xfer(1'b0, 32'hBF000008, 2'd2, 32'h0, 0, 2, 32'h00000001, 1'b0, "rd_wait");
    xfer(1'b1, 32'hBF000000, 2'd2, 32'h12345678, 3, 0, 32'h0, 1'b0, "addr_stall");
    xfer(1'b1, 32'hBF000012, 2'd0, 32'h000000AA, 0, 0, 32'h0, 1'b0, "wr_byte");
    xfer(1'b0, 32'hBF000013, 2'd0, 32'h0, 0, 0, 32'h55000000, 1'b0, "rd_byte");
    xfer(1'b0, 32'hBF000012, 2'd1, 32'h0, 0, 1, 32'hBEEF1234, 1'b0, "rd_half");
    xfer(1'b1, 32'hBF000011, 2'd1, 32'h00001234, 1, 0, 32'h0, 1'b0, "wr_half");
    xfer(1'b0, 32'hBF000007, 2'd3, 32'h0, 0, 0, 32'hA5A5C3C3, 1'b0, "rd_size3");
    xfer(1'b1, 32'hBF000010, 2'd2, 32'hCAFEF00D, 0, 1, 32'hFFFFFFFF, 1'b1, "err_wr");
    xfer(1'b0, 32'hBF000004, 2'd2, 32'h0, 0, 1, 32'h87654321, 1'b1, "err_rd");
    xfer(1'b0, 32'hBF00000C, 2'd2, 32'h0, 1, 0, 32'h0000BEEF, 1'b0, "after_err");

    // Reset while in the data phase: transfer must vanish without a response
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hBF000000; cmd_size = 2'd2;
    cmd_wdata = 32'hDEADBEEF;
    @(negedge HCLK);
    cmd_valid = 1'b0; HREADY = 1'b1;
    @(negedge HCLK);
    chk("mid.hwdata", HWDATA, 32'hDEADBEEF);
    HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    chk("mid.htrans", {30'b0, HTRANS}, 32'd0);
    chk("mid.hwdata_rst", HWDATA, 32'd0);
    chk("mid.haddr_rst", HADDR, 32'd0);
    chk("mid.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid.cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("mid.hprot", {28'b0, HPROT}, 32'h3);
    HRESET = 1'b0; HREADY = 1'b0; hwdata_exp = '0;
    @(negedge HCLK);
    chk("mid.no_rsp", {31'b0, rsp_valid}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      logic        wr;
      logic [1:0]  sz;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'hBF000000 | 32'($urandom_range(0, 31));
      xfer(wr, a, sz, $urandom, 0, 0, $urandom, 1'b0, $sformatf("b2b%0d", i));
    end

    repeat (3) @(negedge HCLK);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
